// File: rtl/vita_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vita_pkg
// Description : Shared types and geometry defaults for the VITA2000 line parser.
// Revision    : 1.0 - initial release
// ============================================================================
package vita_pkg;

    localparam int DEF_H_PIXELS       = 1920;
    localparam int DEF_LINES          = 1080;
    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_WORDS_PER_LINE = DEF_H_PIXELS / DEF_CHANNELS;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        GAP      = 2'd1,
        LINE     = 2'd2,
        CRC_WAIT = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        CODE_NONE = 4'd0,
        CODE_INV  = 4'd1,
        CODE_FS   = 4'd2,
        CODE_FE   = 4'd3,
        CODE_LS   = 4'd4,
        CODE_LE   = 4'd5,
        CODE_CRC  = 4'd6,
        CODE_IMG  = 4'd7,
        CODE_BL   = 4'd8,
        CODE_TP   = 4'd9
    } code_t;

    // Collapse simultaneous flags to the single highest-priority code.
    function automatic code_t decode_code(
        input logic inv, input logic fs,  input logic fe,
        input logic ls,  input logic le,  input logic crc,
        input logic img, input logic bl,  input logic tp
    );
        code_t c;
        c = CODE_NONE;
        if (inv)      c = CODE_INV;
        else if (fs)  c = CODE_FS;
        else if (fe)  c = CODE_FE;
        else if (ls)  c = CODE_LS;
        else if (le)  c = CODE_LE;
        else if (crc) c = CODE_CRC;
        else if (img) c = CODE_IMG;
        else if (bl)  c = CODE_BL;
        else if (tp)  c = CODE_TP;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vita_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : vita_sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module vita_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !sat_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign sat_o = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/vita_line_parser.sv
`default_nettype none
// ============================================================================
// Module      : vita_line_parser
// Description : Frames decoded VITA2000 sync codes into a pixel word stream.
// Revision    : 1.0 - initial release
// ============================================================================
module vita_line_parser
    import vita_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES,
    parameter int WORD_W          = 10,
    parameter int LINE_W          = 11
) (
    input  logic              par_clock,
    input  logic              reset,
    input  logic              FS,
    input  logic              FE,
    input  logic              LS,
    input  logic              LE,
    input  logic              BL,
    input  logic              TP,
    input  logic              IMG,
    input  logic              CRC,
    input  logic              INV,
    input  logic [31:0]       cam_d,
    output logic [31:0]       pix_data,
    output logic              pix_valid,
    output logic              pix_sof,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic [LINE_W-1:0] pix_line,
    output logic              frame_done,
    output logic [LINE_W-1:0] frame_lines,
    output logic              err_sync,
    output logic              err_len,
    output logic              err_lines
);

    localparam logic [WORD_W-1:0] C_WPL = WORD_W'(WORDS_PER_LINE);
    localparam logic [LINE_W-1:0] C_LPF = LINE_W'(LINES_PER_FRAME);

    state_t              state_q, state_d;
    logic [31:0]         hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                sof_pend_q, sof_pend_d;
    logic                sol_pend_q, sol_pend_d;
    logic                fe_q, fe_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                sof_q, sof_d;
    logic                sol_q, sol_d;
    logic                eol_q, eol_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                done_q, done_d;
    logic [LINE_W-1:0]   flines_q, flines_d;
    logic                esync_q, esync_d;
    logic                elen_q, elen_d;
    logic                elines_q, elines_d;

    code_t               w_code;
    logic                w_emit, w_emit_eol, w_restart;
    logic                w_word_clr, w_word_inc, w_line_clr, w_line_inc;
    logic [WORD_W-1:0]   w_word_cnt;
    logic                w_word_sat;
    logic [LINE_W-1:0]   w_line_cnt;
    logic                w_line_sat;

    vita_sat_counter #(.W(WORD_W)) u_word_cnt (
        .clk_i (par_clock),
        .rst_i (reset),
        .clr_i (w_word_clr),
        .inc_i (w_word_inc),
        .cnt_o (w_word_cnt),
        .sat_o (w_word_sat)
    );

    vita_sat_counter #(.W(LINE_W)) u_line_cnt (
        .clk_i (par_clock),
        .rst_i (reset),
        .clr_i (w_line_clr),
        .inc_i (w_line_inc),
        .cnt_o (w_line_cnt),
        .sat_o (w_line_sat)
    );

    assign w_code = decode_code(INV, FS, FE, LS, LE, CRC, IMG, BL, TP);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sof_pend_d  = sof_pend_q;
        sol_pend_d  = sol_pend_q;
        fe_d        = fe_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        sol_d       = 1'b0;
        eol_d       = 1'b0;
        line_d      = line_q;
        done_d      = 1'b0;
        flines_d    = flines_q;
        esync_d     = 1'b0;
        elen_d      = 1'b0;
        elines_d    = 1'b0;
        w_emit      = 1'b0;
        w_emit_eol  = 1'b0;
        w_restart   = 1'b0;
        w_word_clr  = 1'b0;
        w_word_inc  = 1'b0;
        w_line_clr  = 1'b0;
        w_line_inc  = 1'b0;

        case (state_q)
            HUNT: begin
                if (w_code == CODE_FS)
                    w_restart = 1'b1;
            end
            GAP: begin
                case (w_code)
                    CODE_LS: begin
                        state_d    = LINE;
                        w_word_clr = 1'b1;
                        sol_pend_d = 1'b1;
                    end
                    CODE_FS: begin
                        esync_d   = 1'b1;
                        w_restart = 1'b1;
                    end
                    CODE_IMG, CODE_LE, CODE_FE, CODE_CRC, CODE_INV: begin
                        esync_d = 1'b1;
                        state_d = HUNT;
                    end
                    default: ;
                endcase
            end
            LINE: begin
                case (w_code)
                    CODE_IMG: begin
                        // The previous word is only released once we know it is not the last.
                        w_word_inc  = 1'b1;
                        w_emit      = hold_full_q;
                        hold_d      = cam_d;
                        hold_full_d = 1'b1;
                    end
                    CODE_LE, CODE_FE: begin
                        w_emit      = hold_full_q;
                        w_emit_eol  = 1'b1;
                        elen_d      = (w_word_cnt != C_WPL) || w_word_sat;
                        hold_full_d = 1'b0;
                        fe_d        = (w_code == CODE_FE);
                        state_d     = CRC_WAIT;
                    end
                    CODE_FS: begin
                        esync_d   = 1'b1;
                        w_restart = 1'b1;
                    end
                    CODE_LS, CODE_TP, CODE_CRC, CODE_INV: begin
                        esync_d     = 1'b1;
                        hold_full_d = 1'b0;
                        state_d     = HUNT;
                    end
                    default: ;
                endcase
            end
            CRC_WAIT: begin
                if (w_code == CODE_CRC) begin
                    if (fe_q) begin
                        flines_d = w_line_sat ? w_line_cnt : w_line_cnt + 1'b1;
                        done_d   = 1'b1;
                        elines_d = (flines_d != C_LPF);
                        state_d  = HUNT;
                    end else begin
                        w_line_inc = 1'b1;
                        state_d    = GAP;
                    end
                end else if (w_code != CODE_NONE) begin
                    esync_d = 1'b1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (w_restart) begin
            state_d     = LINE;
            w_line_clr  = 1'b1;
            w_word_clr  = 1'b1;
            hold_full_d = 1'b0;
            sof_pend_d  = 1'b1;
            sol_pend_d  = 1'b1;
        end

        if (w_emit) begin
            valid_d    = 1'b1;
            data_d     = hold_q;
            sof_d      = sof_pend_q;
            sol_d      = sol_pend_q;
            eol_d      = w_emit_eol;
            line_d     = w_line_cnt;
            sof_pend_d = 1'b0;
            sol_pend_d = 1'b0;
        end
    end

    always_ff @(posedge par_clock or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sof_pend_q  <= 1'b0;
            sol_pend_q  <= 1'b0;
            fe_q        <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            line_q      <= '0;
            done_q      <= 1'b0;
            flines_q    <= '0;
            esync_q     <= 1'b0;
            elen_q      <= 1'b0;
            elines_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sof_pend_q  <= sof_pend_d;
            sol_pend_q  <= sol_pend_d;
            fe_q        <= fe_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            line_q      <= line_d;
            done_q      <= done_d;
            flines_q    <= flines_d;
            esync_q     <= esync_d;
            elen_q      <= elen_d;
            elines_q    <= elines_d;
        end
    end

    assign pix_data    = data_q;
    assign pix_valid   = valid_q;
    assign pix_sof     = sof_q;
    assign pix_sol     = sol_q;
    assign pix_eol     = eol_q;
    assign pix_line    = line_q;
    assign frame_done  = done_q;
    assign frame_lines = flines_q;
    assign err_sync    = esync_q;
    assign err_len     = elen_q;
    assign err_lines   = elines_q;

endmodule
`default_nettype wire

// File: doc/vita_line_parser.md
# vita_line_parser

Consumes the per-`par_clock` decoded sync flags and 32-bit data word from the VITA2000 LVDS synchronizer and turns them into a framed pixel stream. It tracks frame and line boundaries with a state machine and marks start-of-frame, start-of-line and end-of-line on the output words. It also counts words per line and lines per frame, and reports protocol and length errors. It sits directly downstream of the synchronizer and feeds the frame-buffer writer.

## Interface
- `WORDS_PER_LINE`, default 480: expected IMG words per line (1920 px / 4 channels).
- `LINES_PER_FRAME`, default 1080: expected lines per frame.
- `WORD_W`, default 10: word counter width; saturates at all-ones.
- `LINE_W`, default 11: line counter width; saturates at all-ones.
- `par_clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `FS`, `FE`, `LS`, `LE`, `BL`, `TP`, `IMG`, `CRC`, `INV`, in, 1 each: decoded sync flags, valid each cycle.
- `cam_d`, in, 32: data channels, aligned with the flags.
- `pix_data`, out, 32: pixel word.
- `pix_valid`, out, 1: `pix_data` valid. There is no backpressure.
- `pix_sof`, `pix_sol`, `pix_eol`, out, 1 each: first word of frame, first word of line, last word of line. These are qualified by `pix_valid`.
- `pix_line`, out, `LINE_W`: line index of the current word, 0-based.
- `frame_done`, out, 1: one-cycle pulse after the CRC that follows FE.
- `frame_lines`, out, `LINE_W`: line count, captured at FE.
- `err_sync`, `err_len`, `err_lines`, out, 1 each: one-cycle error pulses.

## Operation
- Input priority when more than one flag is high: INV > FS > FE > LS > LE > CRC > IMG > BL/TP.
- State `HUNT` (the reset state):
  - FS: clear the line counter and go to `LINE` with sof pending.
  - All other codes are ignored.
- State `GAP` (inside a frame, between lines):
  - LS: go to `LINE`; the line counter was already incremented.
  - FS: raise `err_sync` and restart the frame as in `HUNT`.
  - IMG, LE, FE, CRC or INV: raise `err_sync` and go to `HUNT`.
  - BL and TP are ignored.
- State `LINE`:
  - IMG: increment the word counter. If the hold register is full, emit its contents with eol=0. Then load `cam_d` into the hold register.
  - LE or FE: emit the held word with eol=1. Compare the word count with `WORDS_PER_LINE` and pulse `err_len` on mismatch. Go to `CRC_WAIT` and remember whether the code was FE.
  - BL: ignored.
  - LS, TP, CRC or INV: raise `err_sync`, discard the hold register without emitting it, and go to `HUNT`.
  - FS: raise `err_sync`, discard the hold register, and restart the frame.
- State `CRC_WAIT`:
  - CRC after LE: increment the line counter and go to `GAP`.
  - CRC after FE: set `frame_lines` to the line count + 1, pulse `frame_done`, and pulse `err_lines` if `frame_lines` ≠ `LINES_PER_FRAME`. Go to `HUNT`.
  - Any other code: raise `err_sync` and go to `HUNT`.
- Line-length edge cases:
  - LE with zero IMG words emits nothing and raises `err_len`.
  - A one-word line emits a single word with sol, eol and (for the first line) sof all high.
- Counters saturate and never wrap. A saturated word count raises `err_len` at LE.
- `pix_sof` is set on the first word emitted after FS and is cleared after that word is emitted. `pix_sol` is set on the first word emitted in each line.
- The CRC word content is not checked.

## Timing
- All outputs are registered.
- Reset values:
  - All 1-bit outputs are 0.
  - `pix_data` is 0.
  - `pix_line` and `frame_lines` are 0.
  - The state is `HUNT` and the hold register is empty.
- Word latency: a word captured at IMG in cycle n appears on `pix_valid` in cycle m+1, where m is the cycle of the next IMG, LE or FE in that line.
- `err_*` pulses appear in the cycle after the offending input. `frame_done` appears in the cycle after CRC.
- `pix_valid` never asserts on two words from different lines in the same cycle. At most one word is emitted per cycle.
- Reset asserted mid-line: outputs clear asynchronously, and no eol is emitted for the interrupted line.

## Structure
- Shared package `vita_pkg`:
  - state encoding (`HUNT`, `GAP`, `LINE`, `CRC_WAIT`);
  - the default geometry constants (1920, 1080, 4 channels).
- Sub-module `vita_sat_counter`, parameterised by width, with clear, increment and saturation. It is instantiated for the word counter and the line counter.

## Test plan
- Use `WORDS_PER_LINE`=4 and `LINES_PER_FRAME`=2 unless a scenario says otherwise.
- Nominal frame:
  - Input: FS, IMG×4 (`cam_d` = 0x01..0x04), LE, CRC, LS, IMG×4 (0x05..0x08), FE, CRC.
  - Expected: 8 valid words 0x01..0x08; sof on 0x01; sol on 0x01 and 0x05; eol on 0x04 and 0x08; `pix_line` = 0 then 1; `frame_done` with `frame_lines`=2; no errors.
- Short line:
  - Input: FS, IMG×3, LE.
  - Expected: eol on the 3rd word and an `err_len` pulse.
- Missing line: a frame with one line, ending FS…FE, CRC → `frame_done` with `frame_lines`=1 and an `err_lines` pulse.
- Protocol break:
  - Input: INV in the middle of a line after 2 IMG words.
  - Expected: one word emitted with no eol, an `err_sync` pulse, and the state returns to `HUNT`. The next FS restarts cleanly.
- Hunt filtering: IMG, LE and BL before any FS produce no output and no errors.
- Reset mid-line: assert `reset` after 2 IMG words → `pix_valid` goes to 0 immediately, and a following FS frame parses nominally.
